// File: rtl/clk_lock_pkg.sv
// Shared definitions for the MMCM reset/lock sequencer: state encoding, default timing
// constants and status counter widths.
package clk_lock_pkg;

  localparam logic [2:0] MMCM_RST  = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] STABLE    = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAIL      = 3'd4;

  typedef enum logic [2:0] {
    StMmcmRst  = MMCM_RST,
    StWaitLock = WAIT_LOCK,
    StStable   = STABLE,
    StRun      = RUN,
    StFail     = FAIL
  } state_e;

  localparam int unsigned DefSyncStages       = 2;
  localparam int unsigned DefMmcmRstCycles    = 16;
  localparam int unsigned DefLockStableCycles = 1024;
  localparam int unsigned DefLockTimeoutCycles = 100000;
  localparam int unsigned DefMaxRetries       = 4;

  localparam int unsigned LossCntW = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by the async reset.
module sync_bit #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/clk_lock_manager.sv
// Reset/lock sequencer for the MMCM wrapper, clocked by the free-running CLK_100.
// Optional feature macro: LOCK_LOSS_COUNT_EN (saturating count of lock losses in RUN).
module clk_lock_manager
  import clk_lock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES         = DefSyncStages,
  parameter int unsigned MMCM_RST_CYCLES     = DefMmcmRstCycles,
  parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
  parameter int unsigned MAX_RETRIES         = DefMaxRetries
) (
  input  logic                               CLK_100,
  input  logic                               reset_n,
  input  logic                               locked,
  output logic                               mmcm_reset,
  output logic                               sys_reset_n,
  output logic                               lock_fail,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [LossCntW-1:0]                lock_loss_cnt
);

  localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned CntW   =
      $clog2(max3(MMCM_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

  logic              locked_s;
  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              mmcm_reset_q, sys_reset_n_q, lock_fail_q;
  logic              loss_event;

  sync_bit #(
    .Stages(SYNC_STAGES)
  ) u_sync_locked (
    .clk_i (CLK_100),
    .rst_ni(reset_n),
    .d_i   (locked),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    loss_event = 1'b0;
    unique case (state_q)
      StMmcmRst: begin
        if (cnt_q == CntW'(MMCM_RST_CYCLES - 1)) state_d = StWaitLock;
      end
      StWaitLock: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (locked_s) begin
          state_d = StStable;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_d = retry_q + RetryW'(1);
          state_d = (retry_d == RetryW'(MAX_RETRIES)) ? StFail : StMmcmRst;
        end
      end
      StStable: begin
        if (!locked_s) begin
          state_d = StWaitLock;
        end else if (cnt_q == CntW'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = StRun;
          retry_d = '0;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d    = StMmcmRst;
          loss_event = 1'b1;
        end
      end
      StFail: begin
        state_d = StFail;
      end
      default: state_d = StMmcmRst;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {StMmcmRst, StWaitLock, StStable}) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge CLK_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StMmcmRst;
      cnt_q         <= '0;
      retry_q       <= '0;
      mmcm_reset_q  <= 1'b1;
      sys_reset_n_q <= 1'b0;
      lock_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      // Decoded from next state so both resets come straight from flops.
      mmcm_reset_q  <= (state_d == StMmcmRst) || (state_d == StFail);
      sys_reset_n_q <= (state_d == StRun);
      lock_fail_q   <= lock_fail_q | (state_d == StFail);
    end
  end

  assign mmcm_reset  = mmcm_reset_q;
  assign sys_reset_n = sys_reset_n_q;
  assign lock_fail   = lock_fail_q;
  assign retry_cnt   = retry_q;

`ifdef LOCK_LOSS_COUNT_EN
  logic [LossCntW-1:0] loss_cnt_q;

  always_ff @(posedge CLK_100 or negedge reset_n) begin
    if (!reset_n) begin
      loss_cnt_q <= '0;
    end else if (loss_event && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + LossCntW'(1);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  logic unused_loss_event;
  assign unused_loss_event = loss_event;
  assign lock_loss_cnt     = '0;
`endif

endmodule

// File: tb/tb_clk_lock_manager.sv
// Directed bench for clk_lock_manager with short timing parameters.
module tb_clk_lock_manager;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned RstCycles  = 4;
  localparam int unsigned StableCyc  = 8;
  localparam int unsigned TimeoutCyc = 32;
  localparam int unsigned MaxRetries = 2;

`ifdef LOCK_LOSS_COUNT_EN
  localparam logic [31:0] ExpLoss1 = 32'd1;
`else
  localparam logic [31:0] ExpLoss1 = 32'd0;
`endif

  logic       CLK_100 = 1'b0;
  logic       reset_n;
  logic       locked;
  logic       mmcm_reset;
  logic       sys_reset_n;
  logic       lock_fail;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int n;

  always #5 CLK_100 = ~CLK_100;

  clk_lock_manager #(
    .SYNC_STAGES        (SyncStages),
    .MMCM_RST_CYCLES    (RstCycles),
    .LOCK_STABLE_CYCLES (StableCyc),
    .LOCK_TIMEOUT_CYCLES(TimeoutCyc),
    .MAX_RETRIES        (MaxRetries)
  ) dut (
    .CLK_100      (CLK_100),
    .reset_n      (reset_n),
    .locked       (locked),
    .mmcm_reset   (mmcm_reset),
    .sys_reset_n  (sys_reset_n),
    .lock_fail    (lock_fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic tick();
    @(posedge CLK_100);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sig(input int which);
    case (which)
      0:       return {31'd0, mmcm_reset};
      1:       return {31'd0, sys_reset_n};
      2:       return {31'd0, lock_fail};
      default: return {30'd0, retry_cnt};
    endcase
  endfunction

  // Ticks until the selected output equals val; n = ticks taken, or -1 past the budget.
  task automatic count_until(input int which, input logic [31:0] val, input int max,
                             output int cnt);
    cnt = 0;
    while ((sig(which) !== val) && (cnt >= 0)) begin
      if (cnt >= max) begin
        cnt = -1;
      end else begin
        tick();
        cnt++;
      end
    end
  endtask

  // Asserts reset_n mid-cycle, checks outputs asynchronously, releases just after an edge.
  task automatic assert_reset(input string tag);
    reset_n = 1'b0;
    #2;
    check({tag, " mmcm_reset"}, {31'd0, mmcm_reset}, 32'd1);
    check({tag, " sys_reset_n"}, {31'd0, sys_reset_n}, 32'd0);
    check({tag, " lock_fail"}, {31'd0, lock_fail}, 32'd0);
    check({tag, " retry_cnt"}, {30'd0, retry_cnt}, 32'd0);
    check({tag, " lock_loss_cnt"}, {24'd0, lock_loss_cnt}, 32'd0);
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    locked  = 1'b0;
    tick();
    tick();
    check("reset mmcm_reset", {31'd0, mmcm_reset}, 32'd1);
    check("reset sys_reset_n", {31'd0, sys_reset_n}, 32'd0);
    check("reset lock_fail", {31'd0, lock_fail}, 32'd0);
    check("reset retry_cnt", {30'd0, retry_cnt}, 32'd0);
    check("reset lock_loss_cnt", {24'd0, lock_loss_cnt}, 32'd0);

    // Normal bring-up: lock rises 10 cycles after release.
    reset_n = 1'b1;
    count_until(0, 32'd0, 20, n);
    check("t1 mmcm_reset length", n, 32'd4);
    repeat (6) tick();
    locked = 1'b1;
    count_until(1, 32'd1, 40, n);
    check("t1 locked->sys_reset_n", n, 32'd11);
    check("t1 retry_cnt", {30'd0, retry_cnt}, 32'd0);
    check("t1 mmcm_reset low in RUN", {31'd0, mmcm_reset}, 32'd0);

    // Lock loss in RUN for 5 cycles.
    locked = 1'b0;
    count_until(1, 32'd0, 20, n);
    check("t4 loss->sys_reset_n fall", n, 32'd3);
    check("t4 mmcm_reset re-asserted", {31'd0, mmcm_reset}, 32'd1);
    tick();
    tick();
    locked = 1'b1;
    count_until(0, 32'd0, 20, n);
    check("t4 mmcm_reset pulse tail", n, 32'd2);
    count_until(1, 32'd1, 40, n);
    check("t4 relock->sys_reset_n", n, 32'd9);
    check("t4 lock_loss_cnt", {24'd0, lock_loss_cnt}, ExpLoss1);
    check("t4 retry_cnt", {30'd0, retry_cnt}, 32'd0);

    // Lock drop inside the stability window at count 5.
    locked = 1'b0;
    assert_reset("t5 pre");
    count_until(0, 32'd0, 20, n);
    check("t5 mmcm_reset length", n, 32'd4);
    locked = 1'b1;
    repeat (6) tick();
    locked = 1'b0;
    repeat (4) tick();
    check("t5 sys_reset_n held", {31'd0, sys_reset_n}, 32'd0);
    check("t5 no retry", {30'd0, retry_cnt}, 32'd0);
    tick();
    locked = 1'b1;
    count_until(1, 32'd1, 40, n);
    check("t5 full window after relock", n, 32'd11);

    // Reset in RUN, then lock held through MMCM_RST, then reset in STABLE.
    assert_reset("t6 in RUN");
    count_until(0, 32'd0, 20, n);
    check("t6 mmcm_reset length, lock ignored", n, 32'd4);
    tick();
    tick();
    check("t6 in STABLE mmcm_reset low", {31'd0, mmcm_reset}, 32'd0);
    assert_reset("t6 in STABLE");
    count_until(0, 32'd0, 20, n);
    check("t6 restart mmcm_reset length", n, 32'd4);
    count_until(1, 32'd1, 40, n);
    check("t6 restart lock sequence", n, 32'd9);

    // Lock never arrives: two timeouts then FAIL.
    locked = 1'b0;
    assert_reset("t2 pre");
    count_until(0, 32'd0, 20, n);
    check("t2 mmcm_reset length", n, 32'd4);
    count_until(3, 32'd1, 40, n);
    check("t2 first timeout", n, 32'd32);
    check("t2 mmcm_reset retry", {31'd0, mmcm_reset}, 32'd1);
    count_until(2, 32'd1, 60, n);
    check("t2 second timeout->FAIL", n, 32'd36);
    check("t2 retry_cnt", {30'd0, retry_cnt}, 32'd2);
    check("t2 mmcm_reset in FAIL", {31'd0, mmcm_reset}, 32'd1);
    repeat (20) tick();
    check("t2 lock_fail sticky", {31'd0, lock_fail}, 32'd1);
    check("t2 sys_reset_n held", {31'd0, sys_reset_n}, 32'd0);
    check("t2 mmcm_reset held", {31'd0, mmcm_reset}, 32'd1);
    assert_reset("t6 in FAIL");

    // Lock on the second attempt.
    count_until(0, 32'd0, 20, n);
    check("t3 mmcm_reset length", n, 32'd4);
    count_until(3, 32'd1, 40, n);
    check("t3 first timeout", n, 32'd32);
    count_until(0, 32'd0, 20, n);
    check("t3 retry mmcm_reset length", n, 32'd4);
    check("t3 retry_cnt in 2nd attempt", {30'd0, retry_cnt}, 32'd1);
    locked = 1'b1;
    count_until(1, 32'd1, 40, n);
    check("t3 locked->sys_reset_n", n, 32'd11);
    check("t3 retry_cnt cleared", {30'd0, retry_cnt}, 32'd0);

    // Synced lock arrives exactly on the timeout cycle.
    locked = 1'b0;
    assert_reset("tb pre");
    count_until(0, 32'd0, 20, n);
    check("tb mmcm_reset length", n, 32'd4);
    repeat (29) tick();
    locked = 1'b1;
    repeat (3) tick();
    check("tb lock wins over timeout", {30'd0, retry_cnt}, 32'd0);
    check("tb mmcm_reset stays low", {31'd0, mmcm_reset}, 32'd0);
    count_until(1, 32'd1, 40, n);
    check("tb stable window", n, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
